// File: rtl/zwave_uart_rx_fifo.sv
// zwave_uart_rx_fifo: Z-Wave UART receive path.
// Oversampled 8N1 deserialiser (LSB first) feeding a show-ahead byte FIFO
// that is drained one byte per bus read.
// Optional build macro: ZWAVE_RX_PARITY_EN selects 8E1 framing with a
// sticky parity_err output; without it the receiver is 8N1 only.
module zwave_uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 432,
  parameter int FIFO_AW      = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               rxd,
  input  logic               rd_en,
  output logic [7:0]         rd_data,
  output logic               empty,
  output logic               full,
  output logic [FIFO_AW:0]   count,
  output logic               frame_err,
  output logic               overrun,
  input  logic               clr_err,
`ifdef ZWAVE_RX_PARITY_EN
  output logic               parity_err,
`endif
  output logic               irq
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [15:0]      HALF_BIT = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0]      FULL_BIT = 16'(CLKS_PER_BIT);
  localparam logic [FIFO_AW:0] CNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] CNT_ZERO = (FIFO_AW + 1)'(0);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

`ifdef ZWAVE_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE
  } state_t;
`endif

  // Synchroniser and edge-detect history
  logic sync1_r, sync2_r, prev_r;

  // Receiver FSM state
  state_t      state_r, state_n;
  logic [15:0] cnt_r, cnt_n;
  logic [2:0]  idx_r, idx_n;
  logic [7:0]  shift_r, shift_n;
  logic        push_n, ferr_set;
  logic        tc;
  logic        push_r;
  logic [7:0]  push_data_r;
`ifdef ZWAVE_RX_PARITY_EN
  logic        par_bad_r, par_bad_n, perr_set;
  logic        parity_err_r;
`endif

  // FIFO storage and bookkeeping
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [FIFO_AW:0]   count_r, count_n;
  logic               do_pop, do_write, ovr_set;
  logic               frame_err_r, overrun_r, irq_r;

  // Two-stage synchroniser on the pad, preset to the idle level, plus one history stage for edge detect
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= rxd;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Terminal count: the counter is loaded with the interval and reaches 1 on its last cycle
  assign tc = (cnt_r == 16'd1);

  // Receiver next-state logic: mid-bit sampling driven by the baud counter
  always_comb begin
    state_n  = state_r;
    cnt_n    = (cnt_r != 16'd0) ? (cnt_r - 16'd1) : cnt_r;
    idx_n    = idx_r;
    shift_n  = shift_r;
    push_n   = 1'b0;
    ferr_set = 1'b0;
`ifdef ZWAVE_RX_PARITY_EN
    par_bad_n = par_bad_r;
    perr_set  = 1'b0;
`endif
    case (state_r)
      S_IDLE: begin
        if (prev_r && !sync2_r) begin
          state_n = S_START;
          cnt_n   = HALF_BIT;
`ifdef ZWAVE_RX_PARITY_EN
          par_bad_n = 1'b0;
`endif
        end else begin
          state_n = S_IDLE;
        end
      end
      S_START: begin
        if (tc) begin
          if (!sync2_r) begin
            state_n = S_DATA;
            cnt_n   = FULL_BIT;
            idx_n   = 3'd0;
          end else begin
            // Start bit vanished by mid-bit: treat as a glitch
            state_n = S_IDLE;
          end
        end else begin
          state_n = S_START;
        end
      end
      S_DATA: begin
        if (tc) begin
          shift_n[idx_r] = sync2_r;
          cnt_n          = FULL_BIT;
          if (idx_r == 3'd7) begin
`ifdef ZWAVE_RX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end else begin
            idx_n = idx_r + 3'd1;
          end
        end else begin
          state_n = S_DATA;
        end
      end
`ifdef ZWAVE_RX_PARITY_EN
      S_PARITY: begin
        if (tc) begin
          // Even parity: the parity bit must equal the XOR of the data bits
          par_bad_n = (^shift_r) != sync2_r;
          perr_set  = (^shift_r) != sync2_r;
          cnt_n     = FULL_BIT;
          state_n   = S_STOP;
        end else begin
          state_n = S_PARITY;
        end
      end
`endif
      S_STOP: begin
        if (tc) begin
          if (sync2_r) begin
`ifdef ZWAVE_RX_PARITY_EN
            push_n = !par_bad_r;
`else
            push_n = 1'b1;
`endif
            state_n = S_IDLE;
          end else begin
            // Low stop bit: drop the byte and wait out any break condition
            ferr_set = 1'b1;
            state_n  = S_WAIT_IDLE;
          end
        end else begin
          state_n = S_STOP;
        end
      end
      S_WAIT_IDLE: begin
        if (sync2_r) begin
          state_n = S_IDLE;
        end else begin
          state_n = S_WAIT_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Receiver state registers; the push request lands one cycle after the stop sample
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r     <= S_IDLE;
      cnt_r       <= 16'd0;
      idx_r       <= 3'd0;
      shift_r     <= 8'd0;
      push_r      <= 1'b0;
      push_data_r <= 8'd0;
`ifdef ZWAVE_RX_PARITY_EN
      par_bad_r   <= 1'b0;
`endif
    end else begin
      state_r     <= state_n;
      cnt_r       <= cnt_n;
      idx_r       <= idx_n;
      shift_r     <= shift_n;
      push_r      <= push_n;
      push_data_r <= shift_n;
`ifdef ZWAVE_RX_PARITY_EN
      par_bad_r   <= par_bad_n;
`endif
    end
  end

  assign empty = (count_r == CNT_ZERO);
  assign full  = (count_r == CNT_FULL);

  // FIFO control: a pop frees the slot a simultaneous push into a full FIFO needs
  always_comb begin
    do_pop   = rd_en && !empty;
    do_write = push_r && (!full || do_pop);
    ovr_set  = push_r && full && !do_pop;
    if (do_write && !do_pop) begin
      count_n = count_r + CNT_ONE;
    end else if (do_pop && !do_write) begin
      count_n = count_r - CNT_ONE;
    end else begin
      count_n = count_r;
    end
  end

  // FIFO pointers, occupancy and interrupt
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= CNT_ZERO;
      irq_r    <= 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_n;
      irq_r   <= !empty;
    end
  end

  // FIFO data array; contents are only visible while count is non-zero
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr_r] <= push_data_r;
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set
  always_ff @(posedge clk) begin
    if (!resetn) begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
`ifdef ZWAVE_RX_PARITY_EN
      parity_err_r <= 1'b0;
`endif
    end else begin
      if (ferr_set) begin
        frame_err_r <= 1'b1;
      end else if (clr_err) begin
        frame_err_r <= 1'b0;
      end
      if (ovr_set) begin
        overrun_r <= 1'b1;
      end else if (clr_err) begin
        overrun_r <= 1'b0;
      end
`ifdef ZWAVE_RX_PARITY_EN
      if (perr_set) begin
        parity_err_r <= 1'b1;
      end else if (clr_err) begin
        parity_err_r <= 1'b0;
      end
`endif
    end
  end

  assign rd_data   = empty ? 8'd0 : mem[rd_ptr_r];
  assign count     = count_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;
  assign irq       = irq_r;
`ifdef ZWAVE_RX_PARITY_EN
  assign parity_err = parity_err_r;
`endif

endmodule
